simple_des_decrypt_11: RTL and testbench

Receive side of the team's simplified-DES link. The block accepts a 16-bit word {key8, cipher8} over a valid/ready handshake and derives two round keys from a 10-bit key. It runs a two-round Feistel decryption, applying the keys in reverse order, then holds the 8-bit plaintext until the consumer accepts it. One decryption is in flight at a time, under a 5-state FSM.

---
 rtl/simple_des_decrypt_11_pkg.sv | 33 +++
 rtl/simple_des_decrypt_11_if.sv | 19 +
 rtl/simple_des_decrypt_11_round.sv | 19 +
 rtl/simple_des_decrypt_11.sv | 111 +++++++++++
 tb/tb_simple_des_decrypt_11.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/simple_des_decrypt_11_pkg.sv
// Shared definitions for the simplified-DES receive block: FSM encoding,
// key-schedule defaults and the bit-permutation helpers.
package simple_des_decrypt_11_pkg;

    localparam logic [1:0] KEY_PREFIX_DEF = 2'b11;
    localparam int unsigned ROT1_DEF      = 1;
    localparam int unsigned ROT2_DEF      = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        KEYGEN = 3'b001,
        ROUND1 = 3'b010,
        ROUND2 = 3'b011,
        DONE   = 3'b100
    } state_t;

    // Nibble swap; it is its own inverse, so it also serves as IP_inv.
    function automatic logic [7:0] ip8(input logic [7:0] x);
        return {x[3:0], x[7:4]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] x);
        return {x[0], x[3], x[1], x[2]};
    endfunction

    // Left rotate within 10 bits: shift a doubled copy and keep the top half.
    function automatic logic [9:0] rotl10(input logic [9:0] x, input int unsigned n);
        logic [19:0] d;
        d = {x, x} << n;
        return d[19:10];
    endfunction

endpackage

// File: rtl/simple_des_decrypt_11_if.sv
// Word-in / plaintext-out handshake bundle for the decryptor.
interface simple_des_decrypt_11_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_signal;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_signal;

    modport slave (
        input  in_valid, in_signal, out_ready,
        output in_ready, out_valid, out_signal
    );

    modport master (
        output in_valid, in_signal, out_ready,
        input  in_ready, out_valid, out_signal
    );
endinterface

// File: rtl/simple_des_decrypt_11_round.sv
// One Feistel round fK: left half is mixed with F(R,K), right half passes.
module sdes_round_11
    import simple_des_decrypt_11_pkg::*;
(
    input  logic [3:0] i_l,
    input  logic [3:0] i_r,
    input  logic [7:0] i_k,
    output logic [3:0] o_l,
    output logic [3:0] o_r
);
    logic [3:0] w_f;

    // F folds both key nibbles onto R before the P4 permutation.
    always_comb begin
        w_f = p4(i_r ^ i_k[3:0] ^ i_k[7:4]);
        o_l = i_l ^ w_f;
        o_r = i_r;
    end
endmodule

// File: rtl/simple_des_decrypt_11.sv
// Two-round simplified-DES decryptor, one word in flight at a time.
module simple_des_decrypt_11
    import simple_des_decrypt_11_pkg::*;
#(
    parameter logic [1:0]  KEY_PREFIX = KEY_PREFIX_DEF,
    parameter int unsigned ROT1       = ROT1_DEF,
    parameter int unsigned ROT2       = ROT2_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    simple_des_decrypt_11_if.slave  bus
);
    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cipher;
    logic [7:0] r_key8;
    logic [7:0] r_k1;
    logic [7:0] r_k2;
    logic [3:0] r_l;
    logic [3:0] r_r;
    logic [7:0] r_out;

    logic [9:0] w_key10;
    logic [7:0] w_ip;
    logic [3:0] w_r1_l, w_r1_r;
    logic [3:0] w_r2_l, w_r2_r;
    logic       w_in_ready;
    logic       w_out_valid;

    assign w_key10 = {KEY_PREFIX, r_key8};
    assign w_ip    = ip8(r_cipher);

    // Keys are applied in reverse order: K2 in the first round, K1 in the second.
    sdes_round_11 u_round1 (
        .i_l (w_ip[7:4]),
        .i_r (w_ip[3:0]),
        .i_k (r_k2),
        .o_l (w_r1_l),
        .o_r (w_r1_r)
    );

    sdes_round_11 u_round2 (
        .i_l (r_l),
        .i_r (r_r),
        .i_k (r_k1),
        .o_l (w_r2_l),
        .o_r (w_r2_r)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = KEYGEN;
            end
            KEYGEN: w_next = ROUND1;
            ROUND1: w_next = ROUND2;
            ROUND2: w_next = DONE;
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers, each written only in the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cipher <= '0;
            r_key8   <= '0;
            r_k1     <= '0;
            r_k2     <= '0;
            r_l      <= '0;
            r_r      <= '0;
            r_out    <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_key8   <= bus.in_signal[15:8];
                    r_cipher <= bus.in_signal[7:0];
                end
                KEYGEN: begin
                    r_k1 <= 8'(rotl10(w_key10, ROT1));
                    r_k2 <= 8'(rotl10(w_key10, ROT2));
                end
                ROUND1: begin
                    // Swap halves between the rounds.
                    r_l <= w_r1_r;
                    r_r <= w_r1_l;
                end
                ROUND2: r_out <= ip8({w_r2_l, w_r2_r});
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_signal = r_out;
endmodule

// File: tb/tb_simple_des_decrypt_11.sv
// Directed bench for simple_des_decrypt_11 with hand-computed vectors.
module tb_simple_des_decrypt_11;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    simple_des_decrypt_11_if bus();

    simple_des_decrypt_11 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hand over one word, then wait (bounded) for out_valid; returns latency.
    task automatic send_and_wait(input logic [15:0] word, output int lat);
        bus.in_valid  = 1'b1;
        bus.in_signal = word;
        tick();
        bus.in_valid  = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 16) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int c1, c2;
        logic [7:0] v1, v2;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_signal = 16'h0000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready",  16'(bus.in_ready),   16'h1);
        check("rst_out_valid", 16'(bus.out_valid),  16'h0);
        check("rst_out",       16'(bus.out_signal), 16'h00);

        // Word 0x0000 stepped cycle by cycle.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_signal = 16'h0000;
        tick();
        bus.in_valid = 1'b0;
        check("t1_in_ready",  16'(bus.in_ready),  16'h0);
        check("t1_out_valid", 16'(bus.out_valid), 16'h0);
        tick();
        check("k1_zero", 16'(dut.r_k1), 16'h01);
        check("k2_zero", 16'(dut.r_k2), 16'h06);
        tick();
        check("t3_out_valid", 16'(bus.out_valid), 16'h0);
        tick();
        check("t4_out_valid", 16'(bus.out_valid),  16'h1);
        check("t4_out",       16'(bus.out_signal), 16'h32);
        tick();
        check("t5_in_ready",  16'(bus.in_ready),   16'h1);
        check("t5_out_valid", 16'(bus.out_valid),  16'h0);
        check("t5_out_hold",  16'(bus.out_signal), 16'h32);

        // Word 0xFFA5: K1 = K2 = 0xFF.
        send_and_wait(16'hFFA5, lat);
        check("ffa5_lat", 16'(lat), 16'd4);
        check("ffa5_out", 16'(bus.out_signal), 16'h30);
        check("k1_ff",    16'(dut.r_k1), 16'hFF);
        check("k2_ff",    16'(dut.r_k2), 16'hFF);
        tick();

        // Consumer stalls for 10 cycles; stray input words are ignored.
        bus.out_ready = 1'b0;
        send_and_wait(16'hFFA5, lat);
        check("stall_lat", 16'(lat), 16'd4);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = i[0];
            bus.in_signal = 16'h1234;
            tick();
            check("stall_valid", 16'(bus.out_valid),  16'h1);
            check("stall_out",   16'(bus.out_signal), 16'h30);
            check("stall_ready", 16'(bus.in_ready),   16'h0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("unstall_idle",  16'(bus.in_ready),   16'h1);
        check("unstall_valid", 16'(bus.out_valid),  16'h0);
        check("unstall_out",   16'(bus.out_signal), 16'h30);

        // Back-to-back with in_valid held high.
        c1 = 0; c2 = 0; v1 = '0; v2 = '0;
        bus.in_valid  = 1'b1;
        bus.in_signal = 16'h0000;
        tick();
        bus.in_signal = 16'hFFA5;
        for (int c = 1; c <= 9; c++) begin
            if (bus.out_valid) begin
                if (c1 == 0) begin c1 = c; v1 = bus.out_signal; end
                else         begin c2 = c; v2 = bus.out_signal; end
            end
            if (c < 9) tick();
        end
        bus.in_valid = 1'b0;
        check("b2b_first_cyc",  16'(c1), 16'd4);
        check("b2b_first_out",  16'(v1), 16'h32);
        check("b2b_second_cyc", 16'(c2), 16'd9);
        check("b2b_second_out", 16'(v2), 16'h30);
        tick();
        check("b2b_idle", 16'(bus.in_ready), 16'h1);

        // Reset during ROUND1 discards the word.
        bus.in_valid  = 1'b1;
        bus.in_signal = 16'h0000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_in_round1", 16'(dut.r_state), 16'(3'b010));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", 16'(bus.in_ready),   16'h1);
        check("mid_rst_valid", 16'(bus.out_valid),  16'h0);
        check("mid_rst_out",   16'(bus.out_signal), 16'h00);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_no_pulse", 16'(bus.out_valid), 16'h0);
        end
        send_and_wait(16'hFFA5, lat);
        check("post_rst_lat", 16'(lat), 16'd4);
        check("post_rst_out", 16'(bus.out_signal), 16'h30);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
